// File: rtl/logic_basic_delay_arbiter_if.sv
// Stream bundle between INPUTS requesters, the arbiter and the shared downstream stage.
// slave is the arbiter's view; master is the view of whoever drives the requesters and sinks tx.
interface logic_basic_delay_arbiter_if #(
    parameter int WIDTH  = 8,
    parameter int INPUTS = 2
);
    localparam int IDW = (INPUTS > 1) ? $clog2(INPUTS) : 1;

    logic [INPUTS-1:0]       rx_tvalid;
    logic [INPUTS-1:0]       rx_tlast;
    logic [INPUTS*WIDTH-1:0] rx_tdata;
    logic [INPUTS-1:0]       rx_tready;

    logic                    tx_tready;
    logic                    tx_tvalid;
    logic                    tx_tlast;
    logic [WIDTH-1:0]        tx_tdata;
    logic [IDW-1:0]          tx_tid;

    modport slave (
        input  rx_tvalid, rx_tlast, rx_tdata, tx_tready,
        output rx_tready, tx_tvalid, tx_tlast, tx_tdata, tx_tid
    );

    modport master (
        output rx_tvalid, rx_tlast, rx_tdata, tx_tready,
        input  rx_tready, tx_tvalid, tx_tlast, tx_tdata, tx_tid
    );
endinterface

// File: rtl/logic_basic_delay_arbiter.sv
// Round-robin packet-locked arbiter: INPUTS stream requesters onto one registered output tagged with source id.
// Latency: 1 cycle from accepted rx beat to tx_tvalid; sustains 1 beat/cycle while tx_tready is high.
// Backpressure: tx_tvalid & ~tx_tready freezes the output register and deasserts every rx_tready.
module logic_basic_delay_arbiter #(
    parameter int WIDTH  = 8,
    parameter int INPUTS = 2
) (
    input  logic                      aclk,
    input  logic                      areset_n,
    logic_basic_delay_arbiter_if.slave bus
);
    localparam int IDW = (INPUTS > 1) ? $clog2(INPUTS) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    owner_q, owner_d;
    logic [IDW-1:0]    sel, sel_inc;
    logic              grant_en;
    logic              load;
    logic              accept;
    logic              sel_last;
    logic [WIDTH-1:0]  sel_data;
    logic [INPUTS-1:0] rdy;

    logic              tx_vld_q;
    logic              tx_last_q;
    logic [WIDTH-1:0]  tx_data_q;
    logic [IDW-1:0]    tx_tid_q;

    assign load = bus.tx_tready | ~tx_vld_q;

    // Walk downward so the candidate closest to ptr (in wrap order) is assigned last and wins.
    always_comb begin
        int             idx;
        logic [IDW-1:0] cand;
        idx      = 0;
        cand     = '0;
        sel      = ptr_q;
        grant_en = 1'b0;
        if (state_q == LOCKED) begin
            sel      = owner_q;
            grant_en = 1'b1;
        end else begin
            for (int i = INPUTS - 1; i >= 0; i--) begin
                idx = int'(ptr_q) + i;
                if (idx >= INPUTS) begin
                    idx = idx - INPUTS;
                end
                cand = IDW'(idx);
                if (bus.rx_tvalid[cand]) begin
                    sel      = cand;
                    grant_en = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_inc  = (int'(sel) == INPUTS - 1) ? '0 : sel + 1'b1;
        sel_data = bus.rx_tdata[int'(sel)*WIDTH +: WIDTH];
        sel_last = bus.rx_tlast[sel];
        accept   = load & grant_en & bus.rx_tvalid[sel];
        rdy      = '0;
        if (load && grant_en) begin
            rdy[sel] = 1'b1;
        end
    end

    assign bus.rx_tready = rdy;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (accept) begin
            if (sel_last) begin
                state_d = IDLE;
                ptr_d   = sel_inc;
            end else begin
                state_d = LOCKED;
                owner_d = sel;
            end
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            tx_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            if (load) begin
                tx_vld_q <= accept;
            end
        end
    end

    // Payload flops carry no reset; they are only meaningful while tx_tvalid is set.
    always_ff @(posedge aclk) begin
        if (accept) begin
            tx_data_q <= sel_data;
            tx_last_q <= sel_last;
            tx_tid_q  <= sel;
        end
    end

    assign bus.tx_tvalid = tx_vld_q;
    assign bus.tx_tlast  = tx_last_q;
    assign bus.tx_tdata  = tx_data_q;
    assign bus.tx_tid    = tx_tid_q;

    a_rdy_onehot0: assert property (@(posedge aclk) disable iff (!areset_n)
        $onehot0(bus.rx_tready));

    a_tx_stable: assert property (@(posedge aclk) disable iff (!areset_n)
        (bus.tx_tvalid && !bus.tx_tready) |=>
            (bus.tx_tvalid && $stable(bus.tx_tdata) && $stable(bus.tx_tlast) && $stable(bus.tx_tid)));
endmodule

// File: tb/tb_logic_basic_delay_arbiter.sv
// Bench for the arbiter: a 2-input and a 4-input instance checked each cycle against a grant-rule model,
// plus literal expectations on the delivered beat sequences.
module tb_logic_basic_delay_arbiter;
    logic aclk = 1'b0;
    logic areset_n = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge aclk) cyc++;

    // index 0 drives the 2-input instance, index 1 the 4-input instance
    logic [3:0] vld [2];
    logic [3:0] lst [2];
    logic [7:0] dat [2][4];
    logic       trdy [2];

    logic [3:0] o_rdy [2];
    logic       o_vld [2];
    logic       o_lst [2];
    logic [7:0] o_dat [2];
    logic [1:0] o_tid [2];

    logic_basic_delay_arbiter_if #(.WIDTH(8), .INPUTS(2)) if2 ();
    logic_basic_delay_arbiter_if #(.WIDTH(8), .INPUTS(4)) if4 ();

    assign if2.rx_tvalid = vld[0][1:0];
    assign if2.rx_tlast  = lst[0][1:0];
    assign if2.rx_tdata  = {dat[0][1], dat[0][0]};
    assign if2.tx_tready = trdy[0];
    assign if4.rx_tvalid = vld[1];
    assign if4.rx_tlast  = lst[1];
    assign if4.rx_tdata  = {dat[1][3], dat[1][2], dat[1][1], dat[1][0]};
    assign if4.tx_tready = trdy[1];

    assign o_rdy[0] = {2'b00, if2.rx_tready};
    assign o_vld[0] = if2.tx_tvalid;
    assign o_lst[0] = if2.tx_tlast;
    assign o_dat[0] = if2.tx_tdata;
    assign o_tid[0] = {1'b0, if2.tx_tid};
    assign o_rdy[1] = if4.rx_tready;
    assign o_vld[1] = if4.tx_tvalid;
    assign o_lst[1] = if4.tx_tlast;
    assign o_dat[1] = if4.tx_tdata;
    assign o_tid[1] = if4.tx_tid;

    logic_basic_delay_arbiter #(.WIDTH(8), .INPUTS(2)) dut2 (
        .aclk(aclk), .areset_n(areset_n), .bus(if2.slave));
    logic_basic_delay_arbiter #(.WIDTH(8), .INPUTS(4)) dut4 (
        .aclk(aclk), .areset_n(areset_n), .bus(if4.slave));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // ---------------- model: round-robin pointer, packet lock, one output slot ----------------
    bit         m_vld  [2];
    bit         m_lock [2];
    int         m_ptr  [2];
    int         m_own  [2];
    logic [7:0] m_dat  [2];
    bit         m_lst  [2];
    int         m_tid  [2];

    function automatic int nin(input int d);
        return (d == 0) ? 2 : 4;
    endfunction

    function automatic int m_grant(input int d);
        if (m_lock[d]) return m_own[d];
        for (int i = 0; i < nin(d); i++) begin
            if (vld[d][(m_ptr[d] + i) % nin(d)]) return (m_ptr[d] + i) % nin(d);
        end
        return -1;
    endfunction

    int mg;
    always @(posedge aclk or negedge areset_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!areset_n) begin
                m_vld[d]  = 1'b0;
                m_lock[d] = 1'b0;
                m_ptr[d]  = 0;
            end else if (trdy[d] || !m_vld[d]) begin
                mg = m_grant(d);
                if (mg >= 0 && vld[d][mg]) begin
                    m_vld[d] = 1'b1;
                    m_dat[d] = dat[d][mg];
                    m_lst[d] = lst[d][mg];
                    m_tid[d] = mg;
                    if (lst[d][mg]) begin
                        m_lock[d] = 1'b0;
                        m_ptr[d]  = (mg + 1) % nin(d);
                    end else begin
                        m_lock[d] = 1'b1;
                        m_own[d]  = mg;
                    end
                end else begin
                    m_vld[d] = 1'b0;
                end
            end
        end
    end

    // ---------------- per-cycle compare + delivered-beat logs ----------------
    int lg_tid2[$], lg_dat2[$], lg_cyc2[$], lg_tid4[$], lg_dat4[$];
    int cg;
    logic [3:0] er;
    always @(negedge aclk) begin
        if (areset_n) begin
            for (int d = 0; d < 2; d++) begin
                cg = m_grant(d);
                er = '0;
                if ((trdy[d] || !m_vld[d]) && cg >= 0) er[cg] = 1'b1;
                chk($sformatf("rx_tready[dut%0d]", d), o_rdy[d], er);
                chk($sformatf("tx_tvalid[dut%0d]", d), o_vld[d], m_vld[d]);
                if (m_vld[d]) begin
                    chk($sformatf("tx_tdata[dut%0d]", d), o_dat[d], m_dat[d]);
                    chk($sformatf("tx_tlast[dut%0d]", d), o_lst[d], m_lst[d]);
                    chk($sformatf("tx_tid[dut%0d]", d), o_tid[d], m_tid[d]);
                end
                if (o_vld[d] && trdy[d]) begin
                    if (d == 0) begin
                        lg_tid2.push_back(int'(o_tid[d]));
                        lg_dat2.push_back(int'(o_dat[d]));
                        lg_cyc2.push_back(cyc);
                    end else begin
                        lg_tid4.push_back(int'(o_tid[d]));
                        lg_dat4.push_back(int'(o_dat[d]));
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int et[6];
    int ed[6];

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic clear_logs();
        lg_tid2.delete(); lg_dat2.delete(); lg_cyc2.delete();
        lg_tid4.delete(); lg_dat4.delete();
    endtask

    task automatic expect_log(input string nm, input bit four, input int n);
        int sz;
        sz = four ? lg_tid4.size() : lg_tid2.size();
        chk({nm, "_count"}, sz, n);
        for (int i = 0; i < n && i < sz; i++) begin
            chk($sformatf("%s_tid%0d", nm, i), four ? lg_tid4[i] : lg_tid2[i], et[i]);
            chk($sformatf("%s_dat%0d", nm, i), four ? lg_dat4[i] : lg_dat2[i], ed[i]);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            vld[d] = '0; lst[d] = '0; trdy[d] = 1'b1;
            for (int k = 0; k < 4; k++) dat[d][k] = '0;
        end
        tick(2);
        areset_n = 1'b1;
        #1;
        chk("reset_tvalid2", o_vld[0], 0);
        chk("reset_tvalid4", o_vld[1], 0);
        chk("reset_rdy2", o_rdy[0], 0);
        tick(2);

        // alternating single-beat packets
        clear_logs();
        vld[0] = 4'b0011; lst[0] = 4'b0011; dat[0][0] = 8'hA0; dat[0][1] = 8'hB1;
        tick(4);
        vld[0] = '0;
        tick(3);
        et = '{0, 1, 0, 1, 0, 0}; ed = '{'hA0, 'hB1, 'hA0, 'hB1, 0, 0};
        expect_log("t1", 1'b0, 4);

        // 4-beat lock with a competing requester
        clear_logs();
        vld[0] = 4'b0001; lst[0] = 4'b0000; dat[0][0] = 8'h40;
        tick(1);
        dat[0][0] = 8'h41; vld[0] = 4'b0011; lst[0] = 4'b0010; dat[0][1] = 8'h55;
        tick(1);
        dat[0][0] = 8'h42;
        tick(1);
        dat[0][0] = 8'h43; lst[0] = 4'b0011;
        tick(1);
        vld[0] = 4'b0010;
        tick(1);
        vld[0] = '0;
        tick(3);
        et = '{0, 0, 0, 0, 1, 0}; ed = '{'h40, 'h41, 'h42, 'h43, 'h55, 0};
        expect_log("t2", 1'b0, 5);
        if (lg_cyc2.size() == 5) begin
            chk("t2_back_to_back", lg_cyc2[3] - lg_cyc2[0], 3);
            chk("t2_next_pkt_gap", lg_cyc2[4] - lg_cyc2[3], 1);
        end

        // owner bubble while the other requester waits
        clear_logs();
        vld[0] = 4'b0001; lst[0] = 4'b0000; dat[0][0] = 8'h60;
        tick(1);
        vld[0] = 4'b0010; lst[0] = 4'b0010; dat[0][1] = 8'h77;
        tick(3);
        vld[0] = 4'b0011; dat[0][0] = 8'h61;
        tick(1);
        dat[0][0] = 8'h62; lst[0] = 4'b0011;
        tick(1);
        vld[0] = 4'b0010;
        tick(1);
        vld[0] = '0;
        tick(3);
        et = '{0, 0, 0, 1, 0, 0}; ed = '{'h60, 'h61, 'h62, 'h77, 0, 0};
        expect_log("t3", 1'b0, 4);
        if (lg_cyc2.size() == 4) begin
            chk("t3_bubble_span", lg_cyc2[1] - lg_cyc2[0], 4);
            chk("t3_handover", lg_cyc2[3] - lg_cyc2[2], 1);
        end

        // 5-cycle downstream stall
        clear_logs();
        vld[0] = 4'b0001; lst[0] = 4'b0001; dat[0][0] = 8'h80;
        tick(1);
        trdy[0] = 1'b0; dat[0][0] = 8'h81;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_stall_vld", o_vld[0], 1);
            chk("t4_stall_dat", o_dat[0], 8'h80);
            chk("t4_stall_rdy", o_rdy[0], 0);
            tick(1);
        end
        trdy[0] = 1'b1;
        tick(1);
        dat[0][0] = 8'h82;
        tick(1);
        vld[0] = '0;
        tick(3);
        et = '{0, 0, 0, 0, 0, 0}; ed = '{'h80, 'h81, 'h82, 0, 0, 0};
        expect_log("t4", 1'b0, 3);

        // reset in the middle of a 5-beat packet
        vld[0] = 4'b0001; lst[0] = 4'b0000; dat[0][0] = 8'h90;
        tick(1);
        dat[0][0] = 8'h91;
        tick(1);
        dat[0][0] = 8'h92;
        #2;
        areset_n = 1'b0;
        #1;
        chk("t6_async_vld2", o_vld[0], 0);
        chk("t6_async_vld4", o_vld[1], 0);
        vld[0] = '0;
        tick(1);
        areset_n = 1'b1;
        clear_logs();
        vld[0] = 4'b0001; lst[0] = 4'b0001; dat[0][0] = 8'hA5;
        tick(1);
        chk("t6_fresh_vld", o_vld[0], 1);
        chk("t6_fresh_tid", o_tid[0], 0);
        chk("t6_fresh_dat", o_dat[0], 8'hA5);
        vld[0] = '0;
        tick(3);
        et = '{0, 0, 0, 0, 0, 0}; ed = '{'hA5, 0, 0, 0, 0, 0};
        expect_log("t6", 1'b0, 1);

        // 4-input wrap-around from ptr=3
        clear_logs();
        vld[1] = 4'b0100; lst[1] = 4'b1111; dat[1][2] = 8'h22;
        tick(1);
        vld[1] = 4'b0101; dat[1][0] = 8'h0A; dat[1][2] = 8'h2B;
        tick(2);
        vld[1] = '0;
        tick(3);
        et = '{2, 0, 2, 0, 0, 0}; ed = '{'h22, 'h0A, 'h2B, 0, 0, 0};
        expect_log("t5", 1'b1, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
